// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
//
// Purpose:
//   Converts single-cycle trigger pulses into clean, fixed-width output levels.
//   Every accepted trigger produces a pulse_out high phase of exactly
//   HOLD_CYCLES clocks, followed by a low phase of at least GAP_CYCLES clocks.
//   Triggers arriving while a pulse or gap is in progress are counted in a
//   saturating pending counter and issued back-to-back as gaps expire.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous active-low reset (0 = reset)
//   trig       in   1   trigger; every cycle it is high counts as one trigger
//   clear_ovf  in   1   synchronous clear of the sticky overflow flag
//   pulse_out  out  1   stretched output level (registered)
//   busy       out  1   high while a pulse or its trailing gap is in progress
//   pending    out  PW  triggers queued but not yet issued (0..MAX_PENDING)
//   overflow   out  1   sticky: a trigger was dropped because the queue was full
//
// Handshake: there is no back-pressure. trig is sampled every rising edge; a
//   sample is either started directly (IDLE), queued (HIGH/GAP, room left) or
//   dropped and recorded in overflow (queue full). The FSM state is kept in the
//   named enum signal 'state' so external checkers can bind to it.
// -----------------------------------------------------------------------------
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 1000000,
  parameter int GAP_CYCLES  = 500000,
  parameter int MAX_PENDING = 7,
  localparam int PW         = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trig,
  input  logic          clear_ovf,
  output logic          pulse_out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  // Timer must hold the larger of the two phase lengths.
  localparam int MAX_T = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW    = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] HOLD_T   = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] GAP_T    = TW'(GAP_CYCLES);
  localparam logic [TW-1:0] TIMER_1  = TW'(1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);
  localparam logic [PW-1:0] PEND_1   = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          pulse_nxt;
  logic          busy_nxt;
  logic [PW-1:0] pending_nxt;
  logic          overflow_nxt;

  // Queue bookkeeping terms.
  logic gap_end;      // last cycle of the gap phase
  logic queue_dec;    // gap expires and the next pulse comes from the queue
  logic queue_inc;    // this cycle's trigger must go into the queue
  logic ovf_set;      // this cycle's trigger is dropped

  always_comb begin
    gap_end   = (state == ST_GAP) && (timer == TIMER_1);
    queue_dec = gap_end && (pending != '0);
    // A trigger while busy is queued, except on the final gap cycle with an
    // empty queue: there it starts the next pulse directly.
    queue_inc = trig && ((state == ST_HIGH) || (state == ST_GAP))
                && !(gap_end && (pending == '0));
  end

  // Next-state / next-output logic.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pulse_nxt = pulse_out;

    unique case (state)
      ST_IDLE: begin
        if (trig) begin
          state_nxt = ST_HIGH;
          timer_nxt = HOLD_T;
          pulse_nxt = 1'b1;
        end
      end

      ST_HIGH: begin
        if (timer == TIMER_1) begin
          state_nxt = ST_GAP;
          timer_nxt = GAP_T;
          pulse_nxt = 1'b0;
        end else if (timer != '0) begin
          timer_nxt = timer - TIMER_1;
        end
      end

      ST_GAP: begin
        if (timer == TIMER_1) begin
          if ((pending != '0) || trig) begin
            state_nxt = ST_HIGH;
            timer_nxt = HOLD_T;
            pulse_nxt = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            timer_nxt = '0;
            pulse_nxt = 1'b0;
          end
        end else if (timer != '0) begin
          timer_nxt = timer - TIMER_1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
        pulse_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // Pending counter and overflow flag.
  always_comb begin
    pending_nxt = pending;
    ovf_set     = 1'b0;

    if (queue_inc && !queue_dec) begin
      if (pending < PEND_MAX) begin
        pending_nxt = pending + PEND_1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (queue_dec && !queue_inc) begin
      pending_nxt = pending - PEND_1;
    end
    // Both inc and dec: the queued trigger replaces the one being issued,
    // so the count is unchanged even when full and nothing is dropped.

    // A drop in the same cycle as a clear wins, so no drop goes unreported.
    if (ovf_set) begin
      overflow_nxt = 1'b1;
    end else if (clear_ovf) begin
      overflow_nxt = 1'b0;
    end else begin
      overflow_nxt = overflow;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      pulse_out <= pulse_nxt;
      busy      <= busy_nxt;
      pending   <= pending_nxt;
      overflow  <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
//
// Drives pulse_stretcher with HOLD_CYCLES=4, GAP_CYCLES=2, MAX_PENDING=2.
// Each scenario pushes its cycle-by-cycle expected outputs
// {pulse_out, busy, pending[1:0], overflow} into exp_q, then steps the
// stimulus and pops/compares one entry per clock, sampled 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_pulse_stretcher;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int MAXP = 2;
  localparam int PW   = $clog2(MAXP + 1);
  localparam int W    = 3 + PW;

  logic          clk;
  logic          reset;
  logic          trig;
  logic          clear_ovf;
  logic          pulse_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;

  pulse_stretcher #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .trig     (trig),
    .clear_ovf(clear_ovf),
    .pulse_out(pulse_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply inputs, advance one rising edge, settle.
  task automatic drive(input logic t, input logic c);
    trig      = t;
    clear_ovf = c;
    @(posedge clk);
    #1;
  endtask

  // Push n identical expected samples.
  task automatic push_n(input int n, input logic p, input logic b,
                        input int pend, input logic o);
    for (int i = 0; i < n; i++) exp_q.push_back({p, b, PW'(pend), o});
  endtask

  task automatic test_reset();
    logic [W-1:0] got;
    reset = 1'b0;
    trig = 1'b0;
    clear_ovf = 1'b0;
    #2;
    got = {pulse_out, busy, pending, overflow};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", got, {W{1'b0}});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      got = {pulse_out, busy, pending, overflow};
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got=%b exp=%b", i, got, {W{1'b0}});
      end
    end
    @(posedge clk);
    reset = 1'b1;
    push_n(3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] e;
      drive(1'b0, 1'b0);
      got = {pulse_out, busy, pending, overflow};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_release step %0d got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_single_pulse();
    logic [31:0] tm;
    int n;
    tm = 32'h0000_0002;  // trig on step 1
    push_n(4, 1, 1, 0, 0);
    push_n(2, 0, 1, 0, 0);
    push_n(3, 0, 0, 0, 0);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      logic [W-1:0] got, e;
      drive(tm[i], 1'b0);
      got = {pulse_out, busy, pending, overflow};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL single_pulse step %0d got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_queueing();
    logic [31:0] tm;
    int n;
    tm = (32'd1 << 1) | (32'd1 << 3) | (32'd1 << 4);
    push_n(2, 1, 1, 0, 0);
    push_n(1, 1, 1, 1, 0);
    push_n(1, 1, 1, 2, 0);
    push_n(2, 0, 1, 2, 0);
    push_n(4, 1, 1, 1, 0);
    push_n(2, 0, 1, 1, 0);
    push_n(4, 1, 1, 0, 0);
    push_n(2, 0, 1, 0, 0);
    push_n(2, 0, 0, 0, 0);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      logic [W-1:0] got, e;
      drive(tm[i], 1'b0);
      got = {pulse_out, busy, pending, overflow};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL queueing step %0d got=%b exp=%b", i, got, e);
      end
    end
  endtask

  // trig held 5 cycles: 1 direct, 2 queued, 2 dropped. The final drop
  // coincides with clear_ovf, so overflow must still be set. Cleared later.
  task automatic test_overflow();
    logic [31:0] tm, cm;
    int n;
    tm = 32'h0000_003E;               // steps 1..5
    cm = (32'd1 << 5) | (32'd1 << 20);
    push_n(1, 1, 1, 0, 0);
    push_n(1, 1, 1, 1, 0);
    push_n(1, 1, 1, 2, 0);
    push_n(1, 1, 1, 2, 1);
    push_n(2, 0, 1, 2, 1);
    push_n(4, 1, 1, 1, 1);
    push_n(2, 0, 1, 1, 1);
    push_n(4, 1, 1, 0, 1);
    push_n(2, 0, 1, 0, 1);
    push_n(1, 0, 0, 0, 1);
    push_n(2, 0, 0, 0, 0);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      logic [W-1:0] got, e;
      drive(tm[i], cm[i]);
      got = {pulse_out, busy, pending, overflow};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL overflow step %0d got=%b exp=%b", i, got, e);
      end
    end
  endtask

  // Queue full and a trigger on the last gap cycle: pending stays at max,
  // no overflow, next pulse starts on that same edge.
  task automatic test_full_gap_end();
    logic [31:0] tm;
    int n;
    tm = (32'd1 << 1) | (32'd1 << 2) | (32'd1 << 3) | (32'd1 << 7);
    push_n(1, 1, 1, 0, 0);
    push_n(1, 1, 1, 1, 0);
    push_n(2, 1, 1, 2, 0);
    push_n(2, 0, 1, 2, 0);
    push_n(4, 1, 1, 2, 0);
    push_n(2, 0, 1, 2, 0);
    push_n(4, 1, 1, 1, 0);
    push_n(2, 0, 1, 1, 0);
    push_n(4, 1, 1, 0, 0);
    push_n(2, 0, 1, 0, 0);
    push_n(2, 0, 0, 0, 0);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      logic [W-1:0] got, e;
      drive(tm[i], 1'b0);
      got = {pulse_out, busy, pending, overflow};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL full_gap_end step %0d got=%b exp=%b", i, got, e);
      end
    end
  endtask

  // Empty queue + trigger at gap end restarts directly; a trigger in the
  // middle of a gap is queued.
  task automatic test_back_to_back();
    logic [31:0] tm;
    int n;
    tm = (32'd1 << 1) | (32'd1 << 7) | (32'd1 << 12);
    push_n(4, 1, 1, 0, 0);
    push_n(2, 0, 1, 0, 0);
    push_n(4, 1, 1, 0, 0);
    push_n(1, 0, 1, 0, 0);
    push_n(1, 0, 1, 1, 0);
    push_n(4, 1, 1, 0, 0);
    push_n(2, 0, 1, 0, 0);
    push_n(2, 0, 0, 0, 0);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      logic [W-1:0] got, e;
      drive(tm[i], 1'b0);
      got = {pulse_out, busy, pending, overflow};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL back_to_back step %0d got=%b exp=%b", i, got, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] tm;
    logic [W-1:0] got, e;
    int n;
    push_n(1, 1, 1, 0, 0);
    push_n(1, 1, 1, 1, 0);
    for (int i = 1; i <= 2; i++) begin
      drive(1'b1, 1'b0);
      got = {pulse_out, busy, pending, overflow};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL async_pre step %0d got=%b exp=%b", i, got, e);
      end
    end
    trig = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    got = {pulse_out, busy, pending, overflow};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", got, {W{1'b0}});
    end
    @(negedge clk);
    reset = 1'b1;
    // Nothing may resume after release; then a fresh trigger works normally.
    tm = 32'd1 << 7;
    push_n(6, 0, 0, 0, 0);
    push_n(4, 1, 1, 0, 0);
    push_n(2, 0, 1, 0, 0);
    push_n(2, 0, 0, 0, 0);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      drive(tm[i], 1'b0);
      got = {pulse_out, busy, pending, overflow};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL async_post step %0d got=%b exp=%b", i, got, e);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_pulse();
    test_queueing();
    test_overflow();
    test_full_gap_end();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
